// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, in-order imem requests, a small
// response FIFO tagged with PCs, and the registered stage output to decode.
// Redirects flush buffered words and discard responses still in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_p,
  output logic [31:0] pc_n,
  output logic [31:0] inst_out,
  output logic        inst_valid
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W:0]   DEPTH_C    = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
  localparam logic [31:0]      RESET_PC_A = RESET_PC & ~32'h3;

  typedef enum logic [0:0] {FETCH, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       tag_pc_q, tag_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]       pc_p_q, pc_p_d;
  logic [31:0]       inst_q, inst_d;
  logic              valid_q, valid_d;

  logic [31:0]       fifo_data_mem [DEPTH];
  logic [31:0]       fifo_pc_mem   [DEPTH];

  logic [CNT_W:0]    inflight;
  logic              req_fire;
  logic              rsp_keep, rsp_drop;
  logic              push, pop;
  logic [31:0]       redirect_pc_a;

  // Requests in flight plus buffered words bound the FIFO, so a response always has room
  assign inflight       = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem_req_valid = !redirect && (inflight < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign redirect_pc_a  = redirect_pc & ~32'h3;

  assign push = rsp_keep;
  assign pop  = !redirect && !stall && (count_q != '0);

  assign pc_p       = pc_p_q;
  assign pc_n       = pc_p_q + 32'd4;
  assign inst_out   = inst_q;
  assign inst_valid = valid_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // FSM next state: DRAIN exactly while stale responses remain to be discarded
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = (drop_cnt_d != '0) ? DRAIN : FETCH;
    end else begin
      case (state_q)
        FETCH:   state_d = FETCH;
        DRAIN:   if (drop_cnt_d == '0) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  // FSM outputs: classify an arriving response as kept or discarded
  always_comb begin
    rsp_keep = 1'b0;
    rsp_drop = 1'b0;
    case (state_q)
      FETCH:   rsp_keep = imem_rsp_valid && !redirect;
      DRAIN:   rsp_drop = imem_rsp_valid;
      default: rsp_keep = 1'b0;
    endcase
  end

  // Counters, fetch PC and FIFO pointers; redirect overrides everything else
  always_comb begin
    outstanding_d = outstanding_q;
    if (req_fire && !imem_rsp_valid)      outstanding_d = outstanding_q + CNT_W'(1);
    else if (!req_fire && imem_rsp_valid) outstanding_d = outstanding_q - CNT_W'(1);

    fetch_pc_d = fetch_pc_q;
    tag_pc_d   = tag_pc_q;
    drop_cnt_d = drop_cnt_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (redirect) begin
      // No request fires this cycle, so outstanding_d already nets out any response
      fetch_pc_d = redirect_pc_a;
      tag_pc_d   = redirect_pc_a;
      drop_cnt_d = outstanding_d;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CNT_W'(1);
      if (push) begin
        tag_pc_d = tag_pc_q + 32'd4;
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
    end
  end

  // Stage register next value: load FIFO head, bubble when empty, hold on stall
  always_comb begin
    pc_p_d  = pc_p_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (redirect) begin
      inst_d  = NOP;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (count_q != '0) begin
        pc_p_d  = fifo_pc_mem[rd_ptr_q];
        inst_d  = fifo_data_mem[rd_ptr_q];
        valid_d = 1'b1;
      end else begin
        inst_d  = NOP;
        valid_d = 1'b0;
      end
    end
  end

  // Control and stage state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC_A;
      tag_pc_q      <= RESET_PC_A;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pc_p_q        <= RESET_PC;
      inst_q        <= NOP;
      valid_q       <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      tag_pc_q      <= tag_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pc_p_q        <= pc_p_d;
      inst_q        <= inst_d;
      valid_q       <= valid_d;
    end
  end

  // FIFO storage: word and its PC tag; contents need no reset, count gates use
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_mem[wr_ptr_q] <= imem_rsp_data;
      fifo_pc_mem[wr_ptr_q]   <= tag_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order imem model of programmable
// latency. Response word = address ^ 32'hDEAD_0000, so data identifies its PC.
// Request gating on outstanding+buffered < 2 leaves a bubble every third cycle
// with a 1-cycle memory; expected values below account for it.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_p;
  logic [31:0] pc_n;
  logic [31:0] inst_out;
  logic        inst_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(req_valid),
    .imem_req_ready(req_ready),
    .imem_req_addr (req_addr),
    .imem_rsp_valid(rsp_valid),
    .imem_rsp_data (rsp_data),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .pc_p          (pc_p),
    .pc_n          (pc_n),
    .inst_out      (inst_out),
    .inst_valid    (inst_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  // Memory model: accepted requests answered in order, mem_lat cycles later
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    mem_lat = 1;
  int    mcyc    = 0;

  initial begin
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mcyc++;
      if (!rst_n) mq.delete();
      if (mq.size() > 0 && mq[0].due == mcyc) begin
        rsp_valid = 1'b1;
        rsp_data  = mq[0].addr ^ 32'hDEAD_0000;
        void'(mq.pop_front());
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = 32'h0;
      end
      @(negedge clk);
      if (!rst_n) mq.delete();
      else if (req_valid && req_ready) mq.push_back('{addr: req_addr, due: mcyc + mem_lat});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, release just after an edge: cycle 0 begins
  task automatic reset_run(input int lat);
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    req_ready   = 1'b1;
    mem_lat     = lat;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic check_stage(input string tag, input logic [31:0] exp_pc);
    check_eq({tag, "_valid"}, {31'b0, inst_valid}, 32'h1);
    check_eq({tag, "_pc_p"}, pc_p, exp_pc);
    check_eq({tag, "_pc_n"}, pc_n, exp_pc + 32'd4);
    check_eq({tag, "_inst"}, inst_out, exp_pc ^ 32'hDEAD_0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset values and first fetches with a 1-cycle memory
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; req_ready = 1'b1;
    tick(); tick();
    check_eq("rst_pc_p", pc_p, 32'h0);
    check_eq("rst_pc_n", pc_n, 32'h4);
    check_eq("rst_inst", inst_out, 32'h13);
    check_eq("rst_valid", {31'b0, inst_valid}, 32'h0);
    rst_n = 1'b1;
    #1;
    check_eq("t1_req_valid0", {31'b0, req_valid}, 32'h1);
    check_eq("t1_req_addr0", req_addr, 32'h0);
    tick();  // E1
    check_eq("t1_e1_valid", {31'b0, inst_valid}, 32'h0);
    check_eq("t1_e1_addr", req_addr, 32'h4);
    tick();  // E2
    check_eq("t1_e2_valid", {31'b0, inst_valid}, 32'h0);
    check_eq("t1_e2_req_full", {31'b0, req_valid}, 32'h0);
    tick();  // E3
    check_stage("t1_e3", 32'h0);
    tick();  // E4
    check_stage("t1_e4", 32'h4);
    tick();  // E5
    check_eq("t1_e5_bubble", {31'b0, inst_valid}, 32'h0);
    check_eq("t1_e5_nop", inst_out, 32'h13);
    tick();  // E6
    check_stage("t1_e6", 32'h8);

    // 2: stall for three edges
    stall = 1'b1;
    #1;
    check_eq("t2_req_valid", {31'b0, req_valid}, 32'h1);
    check_eq("t2_req_addr", req_addr, 32'h10);
    tick();  // E7
    check_stage("t2_e7", 32'h8);
    check_eq("t2_e7_req", {31'b0, req_valid}, 32'h0);
    tick();  // E8
    check_stage("t2_e8", 32'h8);
    check_eq("t2_e8_req", {31'b0, req_valid}, 32'h0);
    tick();  // E9
    check_stage("t2_e9", 32'h8);
    stall = 1'b0;
    tick();  // E10
    check_stage("t2_e10", 32'hC);
    tick();  // E11
    check_stage("t2_e11", 32'h10);
    tick();  // E12
    check_eq("t2_e12_bubble", {31'b0, inst_valid}, 32'h0);
    tick();  // E13
    check_stage("t2_e13", 32'h14);

    // 3: 3-cycle memory, two in flight, redirect to an unaligned PC
    reset_run(3);
    check_eq("t3_addr0", req_addr, 32'h0);
    tick();  // E1
    check_eq("t3_e1_addr", req_addr, 32'h4);
    tick();  // E2
    redirect = 1'b1; redirect_pc = 32'h103;
    #1;
    check_eq("t3_redir_req", {31'b0, req_valid}, 32'h0);
    tick();  // E3
    redirect = 1'b0;
    #1;
    check_eq("t3_e3_valid", {31'b0, inst_valid}, 32'h0);
    check_eq("t3_e3_req", {31'b0, req_valid}, 32'h0);
    tick();  // E4
    check_eq("t3_e4_req", {31'b0, req_valid}, 32'h1);
    check_eq("t3_e4_addr", req_addr, 32'h100);
    tick();  // E5
    check_eq("t3_e5_addr", req_addr, 32'h104);
    tick(); tick(); tick();  // E8
    check_eq("t3_e8_valid", {31'b0, inst_valid}, 32'h0);
    tick();  // E9
    check_stage("t3_e9", 32'h100);
    tick();  // E10
    check_stage("t3_e10", 32'h104);

    // 4: redirect and stall in the same cycle
    reset_run(1);
    tick(); tick(); tick();  // E3
    check_stage("t4_e3", 32'h0);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    #1;
    check_eq("t4_redir_req", {31'b0, req_valid}, 32'h0);
    tick();  // E4
    check_eq("t4_e4_valid", {31'b0, inst_valid}, 32'h0);
    check_eq("t4_e4_nop", inst_out, 32'h13);
    stall = 1'b0; redirect = 1'b0;
    #1;
    check_eq("t4_e4_addr", req_addr, 32'h40);
    tick(); tick(); tick();  // E7
    check_stage("t4_e7", 32'h40);

    // 5: redirect to the top of the address space, PC wraps
    reset_run(1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    check_eq("t5_redir_req", {31'b0, req_valid}, 32'h0);
    tick();  // E1
    redirect = 1'b0;
    #1;
    check_eq("t5_e1_addr", req_addr, 32'hFFFF_FFFC);
    tick();  // E2
    check_eq("t5_e2_req", {31'b0, req_valid}, 32'h1);
    check_eq("t5_e2_addr", req_addr, 32'h0);
    tick(); tick();  // E4
    check_stage("t5_e4", 32'hFFFF_FFFC);
    tick();  // E5
    check_stage("t5_e5", 32'h0);

    // 6: reset asserted mid-stream with the FIFO full
    reset_run(1);
    tick(); tick(); tick(); tick();  // E4
    check_stage("t6_e4", 32'h4);
    stall = 1'b1;
    tick(); tick();  // E6
    check_stage("t6_e6", 32'h4);
    check_eq("t6_full_req", {31'b0, req_valid}, 32'h0);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_pc_p", pc_p, 32'h0);
    check_eq("t6_rst_pc_n", pc_n, 32'h4);
    check_eq("t6_rst_inst", inst_out, 32'h13);
    check_eq("t6_rst_valid", {31'b0, inst_valid}, 32'h0);
    tick();
    stall = 1'b0;
    rst_n = 1'b1;
    #1;
    check_eq("t6_rel_req", {31'b0, req_valid}, 32'h1);
    check_eq("t6_rel_addr", req_addr, 32'h0);
    tick(); tick(); tick();  // E3
    check_stage("t6_e3", 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
